// File: rtl/usec_sched_pkg.sv
// Shared sizing defaults, slot record layout and scan-state encodings for the usec event scheduler.
package usec_sched_pkg;
  localparam int NSLOT_DEF = 8;
  localparam int SW_DEF    = 3;
  localparam int CW_DEF    = 16;

  localparam logic [CW_DEF-1:0] CNT_UNLIMITED = '0;

  typedef struct packed {
    logic [31:0]       tgt;
    logic [31:0]       period;
    logic [CW_DEF-1:0] count;
    logic              armed;
  } slot_t;

  typedef enum logic [0:0] {
    ST_RST  = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;
endpackage

// File: rtl/usec_time_cmp.sv
// Wrap-safe due test for one slot, plus the reloaded target and its own due test.
// Combinational; "due" means usec is at or past the target within a +/-2^31 us window.
module usec_time_cmp (
  input  logic [31:0] usec,
  input  logic [31:0] slot_time,
  input  logic [31:0] period,
  output logic        due,
  output logic [31:0] next_time,
  output logic        next_due
);
  logic [31:0] w_diff;
  logic [31:0] w_next_diff;

  always_comb begin
    w_diff      = usec - slot_time;
    next_time   = slot_time + period;
    w_next_diff = usec - next_time;
    due         = ~w_diff[31];
    next_due    = ~w_next_diff[31];
  end
endmodule

// File: rtl/usec_event_scheduler.sv
// Round-robin alarm scheduler: one slot compared per clk, evt strobes one clk after the compare; writes accepted every clk out of reset.
// Optional fire timestamp outputs (stamp, stamp_slot) are built when USEC_SCHED_STAMP_EN is defined.
module usec_event_scheduler
  import usec_sched_pkg::*;
#(
  parameter int NSLOT = NSLOT_DEF,
  parameter int SW    = SW_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      usec,
  input  logic             wr_en,
  input  logic [SW-1:0]    wr_slot,
  input  logic             wr_arm,
  input  logic [31:0]      wr_time,
  input  logic [31:0]      wr_period,
  input  logic [CW-1:0]    wr_count,
  output logic             wr_ready,
  output logic [NSLOT-1:0] evt,
  output logic [NSLOT-1:0] armed,
  output logic [NSLOT-1:0] ovr,
  input  logic [NSLOT-1:0] ovr_clr
`ifdef USEC_SCHED_STAMP_EN
  ,
  output logic [31:0]      stamp,
  output logic [SW-1:0]    stamp_slot
`endif
);
  scan_state_t      r_state;
  scan_state_t      w_state_nxt;
  logic             w_scan_en;
  slot_t            r_slot [NSLOT];
  logic [SW-1:0]    r_idx;
  logic [NSLOT-1:0] r_evt;
  logic [NSLOT-1:0] r_ovr;
  logic [NSLOT-1:0] w_ovr_nxt;
  slot_t            w_cur;
  logic             w_due;
  logic             w_next_due;
  logic [31:0]      w_next_time;
  logic             w_wr_ok;
  logic             w_hit_wr;
  logic             w_fire;
  logic             w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RST;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_scan_en   = 1'b0;
    case (r_state)
      ST_RST:  w_state_nxt = ST_SCAN;
      ST_SCAN: w_scan_en   = 1'b1;
      default: w_state_nxt = ST_RST;
    endcase
  end

  assign wr_ready = w_scan_en;
  assign w_cur    = r_slot[r_idx];
  assign w_wr_ok  = wr_en & wr_ready;
  // A write landing on the slot being scanned wins: no fire, no reload.
  assign w_hit_wr = w_wr_ok & (wr_slot == r_idx);
  assign w_fire   = w_scan_en & w_cur.armed & w_due & ~w_hit_wr;
  assign w_last   = (w_cur.period == 32'd0) || (w_cur.count == CW_DEF'(1));

  usec_time_cmp u_cmp (
    .usec      (usec),
    .slot_time (w_cur.tgt),
    .period    (w_cur.period),
    .due       (w_due),
    .next_time (w_next_time),
    .next_due  (w_next_due)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) r_slot[i] <= '0;
    end else begin
      if (w_fire) begin
        if (w_last) begin
          r_slot[r_idx].armed <= 1'b0;
        end else begin
          r_slot[r_idx].tgt <= w_next_time;
          if (w_cur.count != CNT_UNLIMITED) r_slot[r_idx].count <= w_cur.count - CW_DEF'(1);
        end
      end
      if (w_wr_ok) begin
        if (wr_arm) begin
          r_slot[wr_slot].tgt    <= wr_time;
          r_slot[wr_slot].period <= wr_period;
          r_slot[wr_slot].count  <= CW_DEF'(wr_count);
          r_slot[wr_slot].armed  <= 1'b1;
        end else begin
          r_slot[wr_slot].armed  <= 1'b0;
        end
      end
    end
  end

  // Overrun set beats both the host clear and the arm-time clear.
  always_comb begin
    w_ovr_nxt = r_ovr & ~ovr_clr;
    if (w_wr_ok && wr_arm) w_ovr_nxt[wr_slot] = 1'b0;
    if (w_fire && !w_last && w_next_due) w_ovr_nxt[r_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
      r_evt <= '0;
      r_ovr <= '0;
    end else begin
      if (w_scan_en) r_idx <= (r_idx == SW'(NSLOT - 1)) ? '0 : r_idx + SW'(1);
      r_evt <= w_fire ? (NSLOT'(1) << r_idx) : '0;
      r_ovr <= w_ovr_nxt;
    end
  end

  for (genvar g = 0; g < NSLOT; g++) begin : g_armed
    assign armed[g] = r_slot[g].armed;
  end

  assign evt = r_evt;
  assign ovr = r_ovr;

`ifdef USEC_SCHED_STAMP_EN
  logic [31:0]   r_stamp;
  logic [SW-1:0] r_stamp_slot;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stamp      <= '0;
      r_stamp_slot <= '0;
    end else if (w_fire) begin
      r_stamp      <= usec;
      r_stamp_slot <= r_idx;
    end
  end

  assign stamp      = r_stamp;
  assign stamp_slot = r_stamp_slot;
`endif
endmodule

// File: tb/tb_usec_event_scheduler.sv
// Bench for usec_event_scheduler: slot-level behavioural model checked every cycle, plus hand-computed fire times.
module tb_usec_event_scheduler;
  import usec_sched_pkg::*;

  localparam int NSLOT = NSLOT_DEF;
  localparam int SW    = SW_DEF;
  localparam int CW    = CW_DEF;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic [31:0]      usec      = '0;
  logic             wr_en     = 1'b0;
  logic [SW-1:0]    wr_slot   = '0;
  logic             wr_arm    = 1'b0;
  logic [31:0]      wr_time   = '0;
  logic [31:0]      wr_period = '0;
  logic [CW-1:0]    wr_count  = '0;
  logic [NSLOT-1:0] ovr_clr   = '0;
  logic             wr_ready;
  logic [NSLOT-1:0] evt;
  logic [NSLOT-1:0] armed;
  logic [NSLOT-1:0] ovr;
`ifdef USEC_SCHED_STAMP_EN
  logic [31:0]      stamp;
  logic [SW-1:0]    stamp_slot;
`endif

  usec_event_scheduler #(.NSLOT(NSLOT), .SW(SW), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .usec      (usec),
    .wr_en     (wr_en),
    .wr_slot   (wr_slot),
    .wr_arm    (wr_arm),
    .wr_time   (wr_time),
    .wr_period (wr_period),
    .wr_count  (wr_count),
    .wr_ready  (wr_ready),
    .evt       (evt),
    .armed     (armed),
    .ovr       (ovr),
    .ovr_clr   (ovr_clr)
`ifdef USEC_SCHED_STAMP_EN
    ,
    .stamp      (stamp),
    .stamp_slot (stamp_slot)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: per-slot alarm state, scan visits counted since the scheduler started scanning.
  logic [31:0]      m_time   [NSLOT];
  logic [31:0]      m_period [NSLOT];
  int unsigned      m_count  [NSLOT];
  logic [NSLOT-1:0] m_armed, m_ovr, m_evt;
  bit               m_ready;
  int               m_scans;
  logic [31:0]      m_stamp;
  int               m_stamp_slot;

  int          pulses [NSLOT];
  logic [31:0] fire_usec [$];
  int          watch_slot = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NSLOT; i++) begin
      m_time[i] = '0; m_period[i] = '0; m_count[i] = 0;
    end
    m_armed = '0; m_ovr = '0; m_evt = '0;
    m_ready = 1'b0; m_scans = 0; m_stamp = '0; m_stamp_slot = 0;
  endfunction

  function automatic void model_step();
    int               s;
    logic [NSLOT-1:0] next_evt;
    bit               set_ovr;
    next_evt = '0;
    set_ovr  = 1'b0;
    if (!m_ready) begin
      m_ready = 1'b1;
      m_ovr   = m_ovr & ~ovr_clr;
      m_evt   = '0;
      return;
    end
    s = m_scans % NSLOT;
    m_scans++;
    if (m_armed[s] && !(wr_en && int'(wr_slot) == s) && int'(usec - m_time[s]) >= 0) begin
      next_evt[s]  = 1'b1;
      m_stamp      = usec;
      m_stamp_slot = s;
      if (m_period[s] == 0 || m_count[s] == 1) begin
        m_armed[s] = 1'b0;
      end else begin
        m_time[s] = m_time[s] + m_period[s];
        if (m_count[s] != 0) m_count[s] = m_count[s] - 1;
        set_ovr = int'(usec - m_time[s]) >= 0;
      end
    end
    if (wr_en) begin
      if (wr_arm) begin
        m_time[wr_slot]   = wr_time;
        m_period[wr_slot] = wr_period;
        m_count[wr_slot]  = wr_count;
        m_armed[wr_slot]  = 1'b1;
      end else begin
        m_armed[wr_slot]  = 1'b0;
      end
    end
    for (int i = 0; i < NSLOT; i++) begin
      if (set_ovr && i == s) m_ovr[i] = 1'b1;
      else if (ovr_clr[i] || (wr_en && wr_arm && int'(wr_slot) == i)) m_ovr[i] = 1'b0;
    end
    m_evt = next_evt;
  endfunction

  always @(negedge clk) begin
    check("wr_ready", wr_ready, m_ready);
    check("evt", evt, m_evt);
    check("armed", armed, m_armed);
    check("ovr", ovr, m_ovr);
`ifdef USEC_SCHED_STAMP_EN
    check("stamp", stamp, m_stamp);
    check("stamp_slot", stamp_slot, m_stamp_slot);
`endif
    for (int i = 0; i < NSLOT; i++) begin
      if (evt[i] === 1'b1) begin
        pulses[i]++;
        if (i == watch_slot) fire_usec.push_back(usec);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else       model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic hold(input logic [31:0] u, input int n);
    usec = u;
    repeat (n) tick();
  endtask

  task automatic do_write(input int slot, input logic arm, input logic [31:0] t,
                          input logic [31:0] p, input logic [CW-1:0] c);
    wr_en = 1'b1; wr_slot = SW'(slot); wr_arm = arm;
    wr_time = t; wr_period = p; wr_count = c;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_scan(input int slot);
    int n = 0;
    while (m_scans % NSLOT != slot && n < NSLOT) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_evt(input int slot, input string name);
    int n = 0;
    while (evt[slot] !== 1'b1 && n < 3 * NSLOT) begin
      tick();
      n++;
    end
    check(name, evt[slot], 1'b1);
  endtask

  task automatic watch(input int slot);
    watch_slot = slot;
    fire_usec.delete();
    for (int i = 0; i < NSLOT; i++) pulses[i] = 0;
  endtask

  initial begin
    int total;
    model_reset();
    for (int i = 0; i < NSLOT; i++) pulses[i] = 0;
    repeat (3) tick();
    check("reset wr_ready", wr_ready, 1'b0);
    check("reset evt", evt, '0);
    reset = 1'b0;
    tick();
    check("wr_ready after release", wr_ready, 1'b1);

    // One-shot at 100 over a 95..105 ramp.
    usec = 32'd95;
    watch(2);
    do_write(2, 1'b1, 32'd100, 32'd0, '0);
    for (int u = 95; u <= 105; u++) hold(32'(u), NSLOT);
    check("oneshot pulses", pulses[2], 1);
    check("oneshot fire usec", (fire_usec.size() > 0) ? fire_usec[0] : 32'hDEAD_BEEF, 32'd100);
    check("oneshot armed after", armed[2], 1'b0);

    // Periodic with count 3: fires at 10, 15, 20 only.
    usec = 32'd5;
    watch(0);
    do_write(0, 1'b1, 32'd10, 32'd5, 16'd3);
    for (int u = 5; u <= 30; u++) hold(32'(u), NSLOT);
    check("count3 pulses", pulses[0], 3);
    check("count3 fire 1", (fire_usec.size() > 0) ? fire_usec[0] : 32'hDEAD_BEEF, 32'd10);
    check("count3 fire 2", (fire_usec.size() > 1) ? fire_usec[1] : 32'hDEAD_BEEF, 32'd15);
    check("count3 fire 3", (fire_usec.size() > 2) ? fire_usec[2] : 32'hDEAD_BEEF, 32'd20);
    check("count3 armed after", armed[0], 1'b0);

    // Target across the 32-bit wrap.
    usec = 32'hFFFF_FFF0;
    watch(1);
    do_write(1, 1'b1, 32'h0000_0004, 32'd0, '0);
    for (int k = 0; k < 25; k++) hold(32'hFFFF_FFF0 + 32'(k), NSLOT);
    check("wrap pulses", pulses[1], 1);
    check("wrap fire usec", (fire_usec.size() > 0) ? fire_usec[0] : 32'hDEAD_BEEF, 32'd4);

    // Overrun: target far in the past, period 1, unlimited.
    usec = 32'd50;
    watch(3);
    do_write(3, 1'b1, 32'd0, 32'd1, '0);
    wait_evt(3, "overrun first fire");
    check("overrun ovr set", ovr[3], 1'b1);
    wait_scan(3);
    ovr_clr = NSLOT'(8);
    tick();
    ovr_clr = '0;
    check("ovr_clr loses to set", ovr[3], 1'b1);
    check("overrun refire", evt[3], 1'b1);
    ovr_clr = NSLOT'(8);
    tick();
    ovr_clr = '0;
    check("ovr_clr clears", ovr[3], 1'b0);
    pulses[3] = 0;
    repeat (5 * NSLOT) tick();
    check("overrun pulses per pass", pulses[3], 5);
    check("overrun ovr back", ovr[3], 1'b1);
    pulses[3] = 0;
    do_write(3, 1'b0, 32'd0, 32'd0, '0);
    repeat (3 * NSLOT) tick();
    check("cancel stops evt", pulses[3], 0);
    check("cancel armed", armed[3], 1'b0);

    // Collision: rewrite slot 4 in the very clk it is scanned while due.
    usec = 32'd200;
    wait_scan(5);
    do_write(4, 1'b1, 32'd100, 32'd0, '0);
    wait_scan(4);
    watch(4);
    do_write(4, 1'b1, 32'd210, 32'd0, '0);
    check("collision no evt", evt[4], 1'b0);
    check("collision armed", armed[4], 1'b1);
    hold(32'd200, 2 * NSLOT);
    check("collision old time gone", pulses[4], 0);
    hold(32'd210, 2 * NSLOT);
    check("collision new fire", pulses[4], 1);
    check("collision fire usec", (fire_usec.size() > 0) ? fire_usec[0] : 32'hDEAD_BEEF, 32'd210);
`ifdef USEC_SCHED_STAMP_EN
    check("stamp value", stamp, 32'd210);
    check("stamp slot", stamp_slot, 4);
`endif

    // Reset while evt[5] is high.
    do_write(7, 1'b1, 32'h7000_0000, 32'd0, '0);
    do_write(5, 1'b1, 32'd0, 32'd0, '0);
    wait_evt(5, "slot5 fire before reset");
    check("ovr before reset", ovr[3], 1'b1);
    reset = 1'b1;
    #1;
    check("async reset evt", evt, '0);
    check("async reset armed", armed, '0);
    check("async reset ovr", ovr, '0);
`ifdef USEC_SCHED_STAMP_EN
    check("async reset stamp", stamp, 32'd0);
`endif
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    watch(-1);
    repeat (4 * NSLOT) tick();
    total = 0;
    for (int i = 0; i < NSLOT; i++) total += pulses[i];
    check("no events after reset", total, 0);
    check("armed after reset", armed, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
